// File: rtl/distri_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : distri_fifo
//  Brief    : First-word-fall-through FIFO controller over distributed RAM
//             (synchronous write, asynchronous read) with flush and occupancy.
//  Revision : 1.0 - initial release
// ============================================================================
module distri_fifo #(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned XLEN      = 32,
    parameter int unsigned AWIDTH    = $clog2(DEPTH),
    parameter int unsigned AFULL_LVL = DEPTH - 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              push_valid_i,
    input  logic [XLEN-1:0]   push_data_i,
    output logic              push_ready_o,
    output logic              pop_valid_o,
    output logic [XLEN-1:0]   pop_data_o,
    input  logic              pop_ready_i,
    output logic [AWIDTH:0]   count_o,
    output logic              almost_full_o
);

    localparam logic [AWIDTH:0] c_depth = (AWIDTH + 1)'(DEPTH);
    localparam logic [AWIDTH:0] c_afull = (AWIDTH + 1)'(AFULL_LVL);

    logic [XLEN-1:0]   r_mem [DEPTH];
    logic [AWIDTH-1:0] r_wr_ptr;
    logic [AWIDTH-1:0] r_rd_ptr;
    logic [AWIDTH:0]   r_cnt;

    logic w_push_fire;
    logic w_pop_fire;
    logic w_we;

    // Status depends only on registered occupancy, never on the handshake inputs.
    assign push_ready_o  = (r_cnt != c_depth);
    assign pop_valid_o   = (r_cnt != '0);
    assign count_o       = r_cnt;
    assign almost_full_o = (r_cnt >= c_afull);

    assign w_push_fire = push_valid_i & push_ready_o;
    assign w_pop_fire  = pop_valid_o & pop_ready_i;
    assign w_we        = w_push_fire & ~flush_i;

    assign pop_data_o = r_mem[r_rd_ptr];

    always_ff @(posedge clk_i) begin
        if (w_we) begin
            r_mem[r_wr_ptr] <= push_data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else if (flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else if (w_push_fire && w_pop_fire) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
            r_rd_ptr <= r_rd_ptr + 1'b1;
        end else if (w_push_fire) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
            r_cnt    <= r_cnt + 1'b1;
        end else if (w_pop_fire) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
            r_cnt    <= r_cnt - 1'b1;
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk_i) begin
        if (!rst_i) begin
            assert (r_cnt <= c_depth);
            assert (AWIDTH'(r_wr_ptr - r_rd_ptr) == r_cnt[AWIDTH-1:0]);
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_distri_fifo.sv
`default_nettype none
`timescale 1ns/100ps
// ============================================================================
//  Module   : tb_distri_fifo
//  Brief    : Scoreboard bench for distri_fifo against a queue-based model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_distri_fifo;

    localparam int c_depth = 16;
    localparam int c_afull = 14;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        flush_i = 1'b0;
    logic        push_valid_i = 1'b0;
    logic [31:0] push_data_i = '0;
    logic        push_ready_o;
    logic        pop_valid_o;
    logic [31:0] pop_data_o;
    logic        pop_ready_i = 1'b0;
    logic [4:0]  count_o;
    logic        almost_full_o;

    int total = 0;
    int bad   = 0;
    int m_cnt = 0;
    bit mon_en = 1'b0;
    logic [31:0] sb[$];

    distri_fifo #(
        .DEPTH     (c_depth),
        .XLEN      (32),
        .AWIDTH    (4),
        .AFULL_LVL (c_afull)
    ) u_dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .flush_i       (flush_i),
        .push_valid_i  (push_valid_i),
        .push_data_i   (push_data_i),
        .push_ready_o  (push_ready_o),
        .pop_valid_o   (pop_valid_o),
        .pop_data_o    (pop_data_o),
        .pop_ready_i   (pop_ready_i),
        .count_o       (count_o),
        .almost_full_o (almost_full_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus; accepted pushes go straight into the scoreboard.
    task automatic drive(input logic pv, input logic [31:0] pd, input logic pr, input logic fl);
        @(negedge clk_i);
        #1;
        push_valid_i = pv;
        push_data_i  = pd;
        pop_ready_i  = pr;
        flush_i      = fl;
        if (fl) sb.delete();
        else if (pv && m_cnt < c_depth) sb.push_back(pd);
    endtask

    task automatic reset_pulse();
        @(negedge clk_i);
        #1;
        push_valid_i = 1'b0;
        pop_ready_i  = 1'b0;
        flush_i      = 1'b0;
        #1;
        rst_i = 1'b1;
        sb.delete();
        m_cnt = 0;
        #0.5;
        check("rst_push_ready", 32'(push_ready_o), 32'd1);
        check("rst_pop_valid", 32'(pop_valid_o), 32'd0);
        check("rst_count", 32'(count_o), 32'd0);
        check("rst_afull", 32'(almost_full_o), 32'd0);
        #0.3;
        rst_i = 1'b0;
    endtask

    // Monitor: checks status against the model and pops the scoreboard on each transfer.
    initial begin
        forever begin
            @(negedge clk_i);
            #3;
            if (mon_en && !rst_i) begin
                bit push_f, pop_f;
                check("count", 32'(count_o), 32'(m_cnt));
                check("push_ready", 32'(push_ready_o), 32'(m_cnt < c_depth));
                check("pop_valid", 32'(pop_valid_o), 32'(m_cnt > 0));
                check("almost_full", 32'(almost_full_o), 32'(m_cnt >= c_afull));
                push_f = push_valid_i && (m_cnt < c_depth);
                pop_f  = pop_ready_i && (m_cnt > 0);
                if (flush_i) begin
                    m_cnt = 0;
                end else begin
                    if (pop_f) begin
                        if (sb.size() == 0) begin
                            check("sb_underrun", 32'd1, 32'd0);
                        end else begin
                            check("pop_data", pop_data_o, sb.pop_front());
                        end
                    end
                    m_cnt = m_cnt + int'(push_f) - int'(pop_f);
                end
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk_i);
        #2 rst_i = 1'b0;
        mon_en = 1'b1;

        reset_pulse();

        // Ordered fill (17th push must be ignored) and drain
        for (int i = 0; i < 17; i++) drive(1'b1, 32'h1000 + 32'(i), 1'b0, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b0);
        check("full_count", 32'(count_o), 32'd16);
        for (int i = 0; i < 16; i++) drive(1'b0, '0, 1'b1, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b0);
        check("drained_empty", 32'(pop_valid_o), 32'd0);

        // Simultaneous push/pop at count 5 across several wraps
        for (int i = 0; i < 5; i++) drive(1'b1, 32'h2000 + 32'(i), 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) drive(1'b1, 32'h3000 + 32'(i), 1'b1, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b0);
        check("steady_count", 32'(count_o), 32'd5);

        // Full with pop: 0xDEAD must not be stored
        for (int i = 0; i < 11; i++) drive(1'b1, 32'h4000 + 32'(i), 1'b0, 1'b0);
        drive(1'b1, 32'hDEAD, 1'b1, 1'b0);
        drive(1'b1, 32'h4444, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b0);
        check("refill_count", 32'(count_o), 32'd16);
        for (int i = 0; i < 16; i++) drive(1'b0, '0, 1'b1, 1'b0);

        // Flush priority over push and pop
        for (int i = 0; i < 7; i++) drive(1'b1, 32'h5000 + 32'(i), 1'b0, 1'b0);
        drive(1'b1, 32'hBEEF, 1'b1, 1'b1);
        drive(1'b1, 32'h1234, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b0);

        // Empty latency: no same-cycle bypass
        drive(1'b1, 32'hA5A5, 1'b1, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b0);
        check("latency_empty", 32'(count_o), 32'd0);

        // Randomized traffic with occasional flush and a reset mid-stream
        for (int i = 0; i < 800; i++) begin
            if (i == 400) reset_pulse();
            drive(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 2) == 0),
                  1'($urandom_range(0, 59) == 0));
        end
        for (int i = 0; i < 600; i++) begin
            drive(1'($urandom_range(0, 2) == 0), $urandom, 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 99) == 0));
        end
        drive(1'b0, '0, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
